// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: cpu, uart-programmer and ram signal bundle around the ram port arbiter
// slave modport: the arbiter side (takes requests and ram read data, drives grants, responses, ram command)
// master modport: the environment side (requesters plus the ram itself)
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              upg_req;
    logic              upg_we;
    logic              upg_lock;
    logic [ADDR_W-1:0] upg_adr;
    logic [DATA_W-1:0] upg_wdata;
    logic              upg_gnt;
    logic              upg_rvalid;
    logic [DATA_W-1:0] upg_rdata;
    logic              ram_en;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_dat_o;
    logic [DATA_W-1:0] ram_dat_i;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  upg_req, upg_we, upg_lock, upg_adr, upg_wdata,
        output upg_gnt, upg_rvalid, upg_rdata,
        output ram_en, ram_wen, ram_adr, ram_dat_o,
        input  ram_dat_i
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output upg_req, upg_we, upg_lock, upg_adr, upg_wdata,
        input  upg_gnt, upg_rvalid, upg_rdata,
        input  ram_en, ram_wen, ram_adr, ram_dat_o,
        output ram_dat_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous data RAM between the CPU and the UART programmer
// clock: rising-edge clock; reset: synchronous active-high reset
// bus (slave): cpu_*/upg_* requests and responses, ram_* command out and ram_dat_i read data in
module ram_port_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input logic               clock,
    input logic               reset,
    ram_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tag_v_q, tag_v_d;
    logic              tag_o_q, tag_o_d;
    logic              cpu_g, upg_g;
    logic              cpu_rv, upg_rv;
    logic [ADDR_W-1:0] adr_g;
    logic [DATA_W-1:0] wdata_g;

    // last_q: 1 = upg won the last arbitrated grant, 0 = cpu
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cpu_g   = 1'b0;
        upg_g   = 1'b0;
        if (state_q == ARB) begin
            upg_g = bus.upg_req && !(bus.cpu_req && last_q);
            cpu_g = bus.cpu_req && !upg_g;
            if (cpu_g || upg_g)
                last_d = upg_g;
            // with MAX_BURST of 1 the first locked grant already exhausts the burst
            if (upg_g && bus.upg_lock && MAX_BURST > 1) begin
                state_d = BURST;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            upg_g = bus.upg_req;
            cpu_g = bus.cpu_req && !bus.upg_req;
            if (!bus.upg_lock) begin
                state_d = ARB;
                cnt_d   = '0;
            end else if (upg_g) begin
                // a full burst hands the next contested slot to the cpu
                if (int'(cnt_q) + 1 >= MAX_BURST) begin
                    state_d = ARB;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        if (reset) begin
            cpu_g = 1'b0;
            upg_g = 1'b0;
        end
        tag_v_d = (cpu_g && !bus.cpu_we) || (upg_g && !bus.upg_we);
        tag_o_d = upg_g;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tag_v_q <= 1'b0;
            tag_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tag_v_q <= tag_v_d;
            tag_o_q <= tag_o_d;
        end
    end

    assign adr_g   = cpu_g ? bus.cpu_adr : upg_g ? bus.upg_adr : '0;
    assign wdata_g = cpu_g ? bus.cpu_wdata : upg_g ? bus.upg_wdata : '0;

    // a read tag still pending when reset arrives is dropped, not answered
    assign cpu_rv = tag_v_q && !tag_o_q && !reset;
    assign upg_rv = tag_v_q && tag_o_q && !reset;

    assign bus.cpu_gnt    = cpu_g;
    assign bus.upg_gnt    = upg_g;
    assign bus.ram_en     = cpu_g || upg_g;
    assign bus.ram_wen    = cpu_g ? bus.cpu_we : (upg_g && bus.upg_we);
    assign bus.ram_adr    = adr_g;
    assign bus.ram_dat_o  = wdata_g;
    assign bus.cpu_rvalid = cpu_rv;
    assign bus.upg_rvalid = upg_rv;
    assign bus.cpu_rdata  = cpu_rv ? bus.ram_dat_i : '0;
    assign bus.upg_rdata  = upg_rv ? bus.ram_dat_i : '0;
endmodule
